// File: rtl/kamikaze_mem_arbiter_pkg.sv
// Shared constants for the kamikaze memory arbiter: state encoding and the
// default fetch starvation bound.
package kamikaze_mem_arbiter_pkg;

  localparam logic [1:0] KMKZ_ARB_IDLE   = 2'd0;
  localparam logic [1:0] KMKZ_ARB_IGRANT = 2'd1;
  localparam logic [1:0] KMKZ_ARB_DGRANT = 2'd2;
  localparam logic [1:0] KMKZ_ARB_DRAIN  = 2'd3;

  localparam int KMKZ_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = KMKZ_ARB_IDLE,
    ST_IGRANT = KMKZ_ARB_IGRANT,
    ST_DGRANT = KMKZ_ARB_DGRANT,
    ST_DRAIN  = KMKZ_ARB_DRAIN
  } arb_state_e;

endpackage

// File: rtl/kamikaze_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store. Data wins by
// default; fetch is forced after STARVE_LIMIT consecutive data grants.
//
// Handshake: a requester raises req with a stable payload; the arbiter samples
// req/payload only on the cycle it (re)arbitrates. A ready pulse marks the
// completion cycle, and in that same cycle the requester already presents its
// next request (or drops req), so zero-wait memory streams one word per cycle.
module kamikaze_mem_arbiter
  import kamikaze_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = KMKZ_STARVE_LIMIT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic [31:0] i_rdata_o,
  output logic        i_ready_o,
  input  logic        flush_i,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ready_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic [1:0]  state_o,
  output logic [3:0]  starve_cnt_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_e  state_q;
  arb_state_e  grant;
  logic        rearb;
  logic        req_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  starve_cnt_q;

  // Next owner of the bus whenever a decision is due.
  always_comb begin
    grant = ST_IDLE;
    if (d_req_i && (starve_cnt_q < LIMIT)) begin
      grant = ST_DGRANT;
    end else if (i_req_i && !flush_i) begin
      grant = ST_IGRANT;
    end else if (d_req_i) begin
      grant = ST_DGRANT;
    end
  end

  assign rearb = (state_q == ST_IDLE) || mem_ack_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else if (rearb) begin
      state_q <= grant;
      req_q   <= (grant != ST_IDLE);
      case (grant)
        ST_IGRANT: begin
          we_q    <= 1'b0;
          be_q    <= 4'hF;
          addr_q  <= i_addr_i & 32'hFFFF_FFFC;
          wdata_q <= 32'h0;
        end
        ST_DGRANT: begin
          we_q    <= d_we_i;
          be_q    <= d_be_i;
          addr_q  <= d_addr_i;
          wdata_q <= d_wdata_i;
        end
        default: we_q <= 1'b0;
      endcase
    end else if (state_q == ST_IGRANT && flush_i) begin
      // The bus access cannot be aborted; wait out its ack and drop the data.
      state_q <= ST_DRAIN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve_cnt_q <= 4'h0;
    end else if (!i_req_i) begin
      starve_cnt_q <= 4'h0;
    end else if (rearb && grant == ST_IGRANT) begin
      starve_cnt_q <= 4'h0;
    end else if (rearb && grant == ST_DGRANT && starve_cnt_q < LIMIT) begin
      starve_cnt_q <= starve_cnt_q + 4'h1;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign i_ready_o = (state_q == ST_IGRANT) && mem_ack_i && !flush_i;
  assign i_rdata_o = mem_rdata_i;
  assign d_ready_o = (state_q == ST_DGRANT) && mem_ack_i;
  assign d_rdata_o = mem_rdata_i;

  assign state_o      = state_q;
  assign starve_cnt_o = starve_cnt_q;

endmodule
